img_stream_glue: RTL and testbench

IMG_STREAM_GLUE -- requirements
Module: img_stream_glue

---
 rtl/img_stream_glue_pkg.sv | 15 +
 rtl/img_stream_glue.sv | 86 ++++++++
 tb/tb_img_stream_glue.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_stream_glue_pkg.sv
// Shared constants and FSM encoding for the register-block to accelerator
// image streamer.
package img_stream_glue_pkg;

    localparam int IMG_NUM_WORDS = 32;
    localparam int IMG_DATA_W    = 32;
    localparam int IMG_IDX_W     = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/img_stream_glue.sv
// Snapshots a frame of image registers on a start pulse and streams it word
// by word over a valid/ready port, flagging start pulses that arrive while busy.
module img_stream_glue
    import img_stream_glue_pkg::*;
#(
    parameter int NUM_WORDS = IMG_NUM_WORDS,
    parameter int DATA_W    = IMG_DATA_W
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_WORDS*DATA_W-1:0]   i_img_data,
    input  logic                          i_img_cmd_pulse,
    output logic [DATA_W-1:0]             o_img_word,
    output logic                          o_img_valid,
    input  logic                          i_img_ready,
    output logic                          o_img_last,
    output logic [IMG_IDX_W-1:0]          o_img_idx,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_overrun
);

    localparam logic [IMG_IDX_W-1:0] LAST_IDX = IMG_IDX_W'(NUM_WORDS - 1);

    state_e                              state_q, state_d;
    logic [IMG_IDX_W-1:0]                idx_q, idx_d;
    logic [NUM_WORDS-1:0][DATA_W-1:0]    frame_q, frame_d;
    logic                                overrun_q, overrun_d;
    logic                                at_last;

    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (i_img_cmd_pulse) begin
                    frame_d   = i_img_data;
                    idx_d     = '0;
                    overrun_d = 1'b0;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_img_cmd_pulse) overrun_d = 1'b1;
                if (i_img_ready) begin
                    if (at_last) state_d = ST_DONE;
                    else         idx_d   = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                // A pulse on the DONE->IDLE edge is an overrun, never a new start.
                if (i_img_cmd_pulse) overrun_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            frame_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            overrun_q <= overrun_d;
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    assign o_img_valid = (state_q == ST_SEND);
    assign o_img_last  = o_img_valid && at_last;
    assign o_img_word  = o_img_valid ? frame_q[idx_q] : '0;
    assign o_img_idx   = idx_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_done      = (state_q == ST_DONE);
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_img_stream_glue.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor pops
// and compares every accepted word plus done/stall behaviour.
module tb_img_stream_glue;

    localparam int NW = 32;
    localparam int DW = 32;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic [NW*DW-1:0]  i_img_data;
    logic              i_img_cmd_pulse = 1'b0;
    logic [DW-1:0]     o_img_word;
    logic              o_img_valid;
    logic              i_img_ready = 1'b0;
    logic              o_img_last;
    logic [4:0]        o_img_idx;
    logic              o_busy;
    logic              o_done;
    logic              o_overrun;

    logic [31:0] img [NW];

    img_stream_glue #(.NUM_WORDS(NW), .DATA_W(DW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .i_img_data(i_img_data),
        .i_img_cmd_pulse(i_img_cmd_pulse), .o_img_word(o_img_word),
        .o_img_valid(o_img_valid), .i_img_ready(i_img_ready),
        .o_img_last(o_img_last), .o_img_idx(o_img_idx), .o_busy(o_busy),
        .o_done(o_done), .o_overrun(o_overrun)
    );

    always #5 PCLK = ~PCLK;

    always_comb begin
        i_img_data = '0;
        for (int k = 0; k < NW; k++) i_img_data[32*k +: 32] = img[k];
    end

    typedef struct {
        logic [31:0] word;
        int          idx;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ready_mode = 0;   // 0: always high, 1: 1,0,0 pattern, 2: random
    int   rdy_cnt = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Ready driver
    initial begin
        forever begin
            @(posedge PCLK);
            #1;
            case (ready_mode)
                0:       i_img_ready = 1'b1;
                1:       i_img_ready = (rdy_cnt % 3 == 0);
                default: i_img_ready = ($urandom_range(0, 3) != 0);
            endcase
            rdy_cnt++;
        end
    end

    // Monitor / scoreboard
    bit          exp_done = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] pw;
    logic [4:0]  pi;
    logic        pl;
    exp_t        e;

    always @(negedge PCLK) begin
        cyc++;
        if (!PRESETn) begin
            exp_done   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            chk("done_pulse", o_done, exp_done);
            chk("busy_state", o_busy, o_img_valid | o_done);
            if (!o_img_valid) chk("last_without_valid", o_img_last, 1'b0);
            if (stall_prev) begin
                chk("stall_valid", o_img_valid, 1'b1);
                chk("stall_word", o_img_word, pw);
                chk("stall_idx", o_img_idx, pi);
                chk("stall_last", o_img_last, pl);
            end
            exp_done = 1'b0;
            if (o_img_valid && i_img_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none (cycle %0d)", o_img_word, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", o_img_word, e.word);
                    chk("idx", o_img_idx, e.idx);
                    chk("last", o_img_last, e.last);
                    if (e.idx == 0) first_cyc = cyc;
                    if (e.last) begin
                        last_cyc = cyc;
                        exp_done = 1'b1;
                    end
                end
            end
            stall_prev = o_img_valid && !i_img_ready;
            pw = o_img_word;
            pi = o_img_idx;
            pl = o_img_last;
        end
    end

    task automatic pulse(input bit start);
        @(posedge PCLK);
        #1;
        i_img_cmd_pulse = 1'b1;
        if (start)
            for (int k = 0; k < NW; k++) exp_q.push_back('{img[k], k, k == NW - 1});
        @(posedge PCLK);
        #1;
        i_img_cmd_pulse = 1'b0;
        @(negedge PCLK);
        chk("overrun_after_pulse", o_overrun, !start);
        if (start) chk("valid_latency", o_img_valid, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 3000) begin
            @(negedge PCLK);
            n++;
        end
        chk(name, (exp_q.size() == 0) && !o_busy, 1'b1);
    endtask

    task automatic wait_idx(input int v);
        int n = 0;
        while (!(o_img_valid && o_img_idx == 5'(v)) && n < 2000) begin
            @(negedge PCLK);
            n++;
        end
        chk("reach_idx", o_img_idx, v);
    endtask

    task automatic rand_img();
        for (int k = 0; k < NW; k++) img[k] = $urandom;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_valid"}, o_img_valid, 1'b0);
        chk({name, "_last"}, o_img_last, 1'b0);
        chk({name, "_done"}, o_done, 1'b0);
        chk({name, "_overrun"}, o_overrun, 1'b0);
        chk({name, "_busy"}, o_busy, 1'b0);
        chk({name, "_word"}, o_img_word, 32'h0);
        chk({name, "_idx"}, o_img_idx, 5'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NW; k++) img[k] = 32'h0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        repeat (2) @(negedge PCLK);

        // Counting pattern, ready high: back-to-back burst
        for (int k = 0; k < NW; k++) img[k] = 32'hA500_0000 + k;
        ready_mode = 0;
        pulse(1'b1);
        wait_idle("frame_count");
        chk("burst_span", last_cyc - first_cyc, NW - 1);

        // Stalling ready pattern
        rand_img();
        ready_mode = 1;
        rdy_cnt = 0;
        pulse(1'b1);
        wait_idle("frame_toggle");

        // Image registers rewritten mid-frame
        rand_img();
        ready_mode = 2;
        pulse(1'b1);
        repeat (4) @(negedge PCLK);
        for (int k = 0; k < NW; k++) img[k] = 32'hFFFF_FFFF;
        wait_idle("frame_rewrite");

        // Overrun at word 10, then a clean restart clears it
        rand_img();
        ready_mode = 0;
        pulse(1'b1);
        wait_idx(10);
        for (int k = 0; k < NW; k++) img[k] = 32'h1234_0000 + k;
        pulse(1'b0);
        wait_idle("frame_overrun");
        chk("overrun_sticky", o_overrun, 1'b1);
        rand_img();
        ready_mode = 2;
        pulse(1'b1);
        wait_idle("frame_after_overrun");

        // Reset mid-frame
        rand_img();
        ready_mode = 0;
        pulse(1'b1);
        wait_idx(5);
        #1;
        PRESETn = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        repeat (3) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        repeat (5) @(negedge PCLK);
        chk("no_done_after_reset", o_done, 1'b0);
        rand_img();
        pulse(1'b1);
        wait_idle("frame_after_reset");

        // Pulse coincident with the DONE cycle
        rand_img();
        ready_mode = 0;
        pulse(1'b1);
        begin
            int n = 0;
            while (!(o_img_last && i_img_ready) && n < 2000) begin
                @(negedge PCLK);
                n++;
            end
            chk("reach_last", o_img_last, 1'b1);
        end
        pulse(1'b0);
        chk("done_pulse_idle", o_busy, 1'b0);
        repeat (40) @(negedge PCLK);
        chk("no_second_frame", o_img_valid, 1'b0);
        chk("overrun_done_cycle", o_overrun, 1'b1);

        // A few random frames
        for (int f = 0; f < 3; f++) begin
            rand_img();
            ready_mode = 2;
            pulse(1'b1);
            wait_idle("frame_random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
